// File: rtl/cook_timer_if.sv
// Command and status bundle for the cook timer.
// The controller drives the command pulses; the timer returns time and state.
interface cook_timer_if;
    logic        add_10sec;
    logic        add_1min;
    logic        set_30sec;
    logic        start_timer;
    logic        pause_timer;
    logic        resume_timer;
    logic        clear_timer;
    logic [11:0] set_time_sec;
    logic [11:0] remaining_sec;
    logic [5:0]  remaining_mm;
    logic [5:0]  remaining_ss;
    logic        timer_completed;
    logic        timer_running;
    logic        timer_paused;

    modport master (
        output add_10sec, add_1min, set_30sec,
        output start_timer, pause_timer, resume_timer, clear_timer,
        input  set_time_sec, remaining_sec, remaining_mm, remaining_ss,
        input  timer_completed, timer_running, timer_paused
    );

    modport slave (
        input  add_10sec, add_1min, set_30sec,
        input  start_timer, pause_timer, resume_timer, clear_timer,
        output set_time_sec, remaining_sec, remaining_mm, remaining_ss,
        output timer_completed, timer_running, timer_paused
    );
endinterface

// File: rtl/cook_timer.sv
// Kitchen countdown timer: programmable cook time, start/pause/resume/clear,
// with a divider-free minutes/seconds split kept alongside the seconds count.
module cook_timer #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int MAX_SEC = 3599
) (
    input  logic        clk,
    input  logic        reset,
    cook_timer_if.slave bus
);
    localparam int                 PRESC_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
    localparam logic [5:0]         MAX_MM     = 6'(MAX_SEC / 60);
    localparam logic [5:0]         MAX_SS     = 6'(MAX_SEC % 60);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [11:0]        set_time_q, set_time_d;
    logic [11:0]        rem_q, rem_d;
    logic [5:0]         mm_q, mm_d;
    logic [5:0]         ss_q, ss_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               done_q, done_d;
    logic               running_q, running_d;
    logic               paused_q, paused_d;

    logic [6:0] inc;
    logic       tick;
    logic       pause_cmd;
    logic       resume_cmd;
    logic       rem_sat;

    function automatic logic over_max(input logic [11:0] v, input logic [6:0] add);
        logic [12:0] sum;
        sum = {1'b0, v} + {6'b0, add};
        return sum > 13'(MAX_SEC);
    endfunction

    function automatic logic [11:0] sat_add(input logic [11:0] v, input logic [6:0] add);
        logic [12:0] sum;
        sum = {1'b0, v} + {6'b0, add};
        return (sum > 13'(MAX_SEC)) ? 12'(MAX_SEC) : sum[11:0];
    endfunction

    // Adds at most 100 s, so at most two minute carries are needed.
    function automatic logic [11:0] mmss_add(input logic [5:0] mm, input logic [5:0] ss,
                                             input logic sat, input logic [6:0] add);
        logic [7:0] s;
        logic [5:0] m;
        if (sat) begin
            return {MAX_MM, MAX_SS};
        end
        s = {2'b0, ss} + {1'b0, add};
        m = mm;
        if (s >= 8'd120) begin
            s = s - 8'd120;
            m = m + 6'd2;
        end else if (s >= 8'd60) begin
            s = s - 8'd60;
            m = m + 6'd1;
        end
        return {m, s[5:0]};
    endfunction

    function automatic logic [11:0] mmss_dec(input logic [5:0] mm, input logic [5:0] ss);
        if (ss == 6'd0) begin
            return {mm - 6'd1, 6'd59};
        end
        return {mm, ss - 6'd1};
    endfunction

    // set_30sec on a zero time and +30 are the same result, so one adder serves all edits.
    assign inc = (bus.set_30sec ? 7'd30 : 7'd0)
               + (bus.add_10sec ? 7'd10 : 7'd0)
               + (bus.add_1min  ? 7'd60 : 7'd0);

    assign tick       = (presc_q == PRESC_LAST);
    assign pause_cmd  = bus.pause_timer & ~bus.start_timer;
    assign resume_cmd = bus.resume_timer & ~bus.start_timer & ~bus.pause_timer;
    assign rem_sat    = over_max(rem_q, inc);

    always_comb begin
        state_d    = state_q;
        set_time_d = set_time_q;
        rem_d      = rem_q;
        mm_d       = mm_q;
        ss_d       = ss_q;
        presc_d    = presc_q;
        done_d     = 1'b0;

        if (bus.clear_timer) begin
            state_d    = IDLE;
            set_time_d = 12'd0;
            rem_d      = 12'd0;
            mm_d       = 6'd0;
            ss_d       = 6'd0;
            presc_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // remaining mirrors the programmed time while idle
                    set_time_d    = sat_add(set_time_q, inc);
                    rem_d         = set_time_d;
                    {mm_d, ss_d}  = mmss_add(mm_q, ss_q, rem_sat, inc);
                    if (bus.start_timer && (set_time_d != 12'd0)) begin
                        state_d = RUNNING;
                        presc_d = '0;
                    end
                end
                RUNNING: begin
                    if (tick) begin
                        presc_d      = '0;
                        rem_d        = rem_q - 12'd1;
                        {mm_d, ss_d} = mmss_dec(mm_q, ss_q);
                        if (rem_q == 12'd1) begin
                            done_d     = 1'b1;
                            set_time_d = 12'd0;
                            state_d    = IDLE;
                        end else if (pause_cmd) begin
                            state_d = PAUSED;
                        end
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                        if (pause_cmd) begin
                            state_d = PAUSED;
                        end
                    end
                end
                PAUSED: begin
                    set_time_d   = sat_add(set_time_q, inc);
                    rem_d        = sat_add(rem_q, inc);
                    {mm_d, ss_d} = mmss_add(mm_q, ss_q, rem_sat, inc);
                    if (resume_cmd) begin
                        state_d = RUNNING;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        running_d = (state_d == RUNNING);
        paused_d  = (state_d == PAUSED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            set_time_q <= 12'd0;
            rem_q      <= 12'd0;
            mm_q       <= 6'd0;
            ss_q       <= 6'd0;
            presc_q    <= '0;
            done_q     <= 1'b0;
            running_q  <= 1'b0;
            paused_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            set_time_q <= set_time_d;
            rem_q      <= rem_d;
            mm_q       <= mm_d;
            ss_q       <= ss_d;
            presc_q    <= presc_d;
            done_q     <= done_d;
            running_q  <= running_d;
            paused_q   <= paused_d;
        end
    end

    assign bus.set_time_sec    = set_time_q;
    assign bus.remaining_sec   = rem_q;
    assign bus.remaining_mm    = mm_q;
    assign bus.remaining_ss    = ss_q;
    assign bus.timer_completed = done_q;
    assign bus.timer_running   = running_q;
    assign bus.timer_paused    = paused_q;
endmodule

// File: tb/tb_cook_timer.sv
// Bench for cook_timer: directed scenarios with literal expectations, then
// random command traffic checked every cycle against a seconds-level model.
module tb_cook_timer;
    localparam int HZ  = 10;
    localparam int MAX = 3599;

    localparam logic [6:0] C_CLR = 7'b1000000;
    localparam logic [6:0] C_STA = 7'b0100000;
    localparam logic [6:0] C_PAU = 7'b0010000;
    localparam logic [6:0] C_RES = 7'b0001000;
    localparam logic [6:0] C_S30 = 7'b0000100;
    localparam logic [6:0] C_A1M = 7'b0000010;
    localparam logic [6:0] C_A10 = 7'b0000001;

    logic clk = 1'b0;
    logic reset = 1'b1;
    cook_timer_if bus();

    cook_timer #(.CLK_HZ(HZ), .MAX_SEC(MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    // Model: time in whole seconds plus cycles elapsed in the current second.
    int m_set = 0, m_rem = 0, m_cyc = 0;
    bit m_run = 0, m_pause = 0, m_done = 0;

    function automatic int cap(input int v);
        return (v > MAX) ? MAX : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int add;
        m_done = 0;
        add = 30 * int'(bus.set_30sec) + 10 * int'(bus.add_10sec) + 60 * int'(bus.add_1min);
        if (reset || bus.clear_timer) begin
            m_set = 0; m_rem = 0; m_cyc = 0; m_run = 0; m_pause = 0;
        end else if (m_run) begin
            m_cyc++;
            if (m_cyc == HZ) begin
                m_cyc = 0;
                m_rem--;
                if (m_rem == 0) begin
                    m_done = 1; m_set = 0; m_run = 0;
                end
            end
            if (m_run && bus.pause_timer && !bus.start_timer) begin
                m_run = 0; m_pause = 1;
            end
        end else if (m_pause) begin
            m_set = cap(m_set + add);
            m_rem = cap(m_rem + add);
            if (bus.resume_timer && !bus.start_timer && !bus.pause_timer) begin
                m_pause = 0; m_run = 1;
            end
        end else begin
            m_set = cap(m_set + add);
            m_rem = m_set;
            if (bus.start_timer && m_set > 0) begin
                m_run = 1; m_cyc = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_set",     bus.set_time_sec,    m_set);
            chk("cmp_rem",     bus.remaining_sec,   m_rem);
            chk("cmp_mm",      bus.remaining_mm,    m_rem / 60);
            chk("cmp_ss",      bus.remaining_ss,    m_rem % 60);
            chk("cmp_done",    bus.timer_completed, m_done);
            chk("cmp_running", bus.timer_running,   m_run);
            chk("cmp_paused",  bus.timer_paused,    m_pause);
        end
    end

    task automatic step(input logic [6:0] c);
        {bus.clear_timer, bus.start_timer, bus.pause_timer, bus.resume_timer,
         bus.set_30sec, bus.add_1min, bus.add_10sec} = c;
        @(posedge clk);
        #1;
        {bus.clear_timer, bus.start_timer, bus.pause_timer, bus.resume_timer,
         bus.set_30sec, bus.add_1min, bus.add_10sec} = 7'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(7'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_set"},  bus.set_time_sec,    0);
        chk({tag, "_rem"},  bus.remaining_sec,   0);
        chk({tag, "_mm"},   bus.remaining_mm,    0);
        chk({tag, "_ss"},   bus.remaining_ss,    0);
        chk({tag, "_done"}, bus.timer_completed, 0);
        chk({tag, "_run"},  bus.timer_running,   0);
        chk({tag, "_pau"},  bus.timer_paused,    0);
    endtask

    initial begin
        int  edges;
        bit  seen;
        logic [6:0] c;

        {bus.clear_timer, bus.start_timer, bus.pause_timer, bus.resume_timer,
         bus.set_30sec, bus.add_1min, bus.add_10sec} = 7'b0;
        #1;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        cmp_en = 1'b1;
        chk_zero("reset");

        // 30 s cook started in the same cycle it is programmed
        step(C_S30 | C_STA);
        chk("s1_run", bus.timer_running, 1);
        chk("s1_rem", bus.remaining_sec, 30);
        idle(9);
        chk("s1_rem_9", bus.remaining_sec, 30);
        idle(1);
        chk("s1_rem_10", bus.remaining_sec, 29);
        edges = 10;
        seen  = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            step(7'b0);
            edges++;
            if (bus.timer_completed) seen = 1;
        end
        chk("s1_done_edge", edges, 300);
        chk("s1_set0", bus.set_time_sec, 0);
        chk("s1_idle", bus.timer_running, 0);
        idle(1);
        chk("s1_done_pulse", bus.timer_completed, 0);

        // saturation of the programmed time
        for (int i = 0; i < 59; i++) step(C_A1M);
        chk("s2_set59", bus.set_time_sec, 3540);
        step(C_A1M);
        chk("s2_set", bus.set_time_sec, 3599);
        chk("s2_mm", bus.remaining_mm, 59);
        chk("s2_ss", bus.remaining_ss, 59);
        step(C_A10 | C_S30);
        chk("s2_hold", bus.set_time_sec, 3599);
        step(C_CLR);
        chk_zero("s2_clr");

        // pause keeps the partial second; 15 s reached by counting down from 30
        step(C_S30 | C_STA);
        idle(150);
        chk("s3_rem15", bus.remaining_sec, 15);
        idle(33);
        step(C_PAU);
        chk("s3_rem12", bus.remaining_sec, 12);
        chk("s3_paused", bus.timer_paused, 1);
        idle(100);
        chk("s3_hold", bus.remaining_sec, 12);
        step(C_RES);
        chk("s3_resumed", bus.timer_running, 1);
        idle(5);
        chk("s3_rem_5", bus.remaining_sec, 12);
        idle(1);
        chk("s3_rem_6", bus.remaining_sec, 11);
        step(C_CLR);

        // edits while paused
        step(C_S30 | C_STA);
        idle(183);
        step(C_PAU);
        chk("s4_rem12", bus.remaining_sec, 12);
        step(C_A10 | C_A1M);
        chk("s4_rem", bus.remaining_sec, 82);
        chk("s4_mm", bus.remaining_mm, 1);
        chk("s4_ss", bus.remaining_ss, 22);
        chk("s4_set", bus.set_time_sec, 100);
        chk("s4_model_rem", m_rem, 82);
        step(C_CLR);

        // pause on the final tick: completion wins
        step(C_S30 | C_STA);
        idle(290);
        chk("s5_rem1", bus.remaining_sec, 1);
        idle(9);
        step(C_PAU);
        chk("s5_done", bus.timer_completed, 1);
        chk("s5_paused", bus.timer_paused, 0);
        chk("s5_running", bus.timer_running, 0);
        chk("s5_rem", bus.remaining_sec, 0);
        chk("s5_model_done", m_done, 1);

        // clear and reset while counting
        step(C_S30 | C_STA);
        idle(25);
        chk("s6_rem28", bus.remaining_sec, 28);
        step(C_CLR | C_STA | C_A10);
        chk_zero("s6_clr");
        step(C_S30 | C_STA);
        idle(25);
        reset = 1'b1;
        step(C_STA | C_PAU | C_A10);
        reset = 1'b0;
        chk_zero("s6_rst");

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            c = 7'b0;
            c[6] = ($urandom_range(0, 149) == 0);
            c[5] = ($urandom_range(0, 14) == 0);
            c[4] = ($urandom_range(0, 29) == 0);
            c[3] = ($urandom_range(0, 9) == 0);
            c[2] = ($urandom_range(0, 19) == 0);
            c[1] = ($urandom_range(0, 24) == 0);
            c[0] = ($urandom_range(0, 14) == 0);
            reset = ($urandom_range(0, 799) == 0);
            step(c);
        end
        reset = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
